// File: rtl/layer_pkg.sv
// Shared types and helpers for the time-multiplexed fully-connected layer.
package layer_pkg;

   localparam int DATA_W = 16;

   typedef enum logic [1:0] {IDLE, MAC, EMIT, DONE} state_e;

   function automatic int rom_base(input int n, input int num_inputs);
      return n * (num_inputs + 1);
   endfunction

   function automatic logic [DATA_W-1:0] relu16(input logic [DATA_W-1:0] x);
      return x[DATA_W-1] ? '0 : x;
   endfunction

endpackage

// File: rtl/layer_mac_scheduler_if.sv
// Weight/bias ROM read port plus the result stream handshake of the layer scheduler.
interface layer_mac_scheduler_if
   import layer_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int IDX_W  = 4
);
   logic [ADDR_W-1:0] rom_addr;
   logic              rom_en;
   logic [DATA_W-1:0] rom_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [IDX_W-1:0]  out_idx;

   modport master (
      output rom_addr, rom_en, out_valid, out_data, out_idx,
      input  rom_data, out_ready
   );

   modport slave (
      input  rom_addr, rom_en, out_valid, out_data, out_idx,
      output rom_data, out_ready
   );
endinterface

// File: rtl/mac16.sv
// Shared 16-bit multiply-accumulate: acc wraps mod 2^16, product keeps its low 16 bits.
module mac16
   import layer_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              clr,
   input  logic              en,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] acc
);
   logic [DATA_W-1:0] acc_q, acc_d, prod;

   always_comb begin
      prod  = a * b;
      acc_d = acc_q;
      if (clr)     acc_d = '0;
      else if (en) acc_d = acc_q + prod;
   end

   always_ff @(posedge clk) begin
      if (reset) acc_q <= '0;
      else       acc_q <= acc_d;
   end

   assign acc = acc_q;
endmodule

// File: rtl/layer_mac_scheduler.sv
// Evaluates one fully-connected layer by sharing a single mac16 across all neurons,
// streaming bias+ReLU results over a valid/ready port.
//   state | meaning
//   IDLE  | waiting for start
//   MAC   | steps k=0..NUM_INPUTS+1: ROM reads for k<=NUM_INPUTS, accumulate for k>=1
//   EMIT  | result of neuron n held on the output until handshake
//   DONE  | one-cycle done pulse, then back to IDLE
module layer_mac_scheduler
   import layer_pkg::*;
#(
   parameter int NUM_INPUTS  = 10,
   parameter int NUM_NEURONS = 16,
   parameter int ADDR_W      = 8
)(
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic [DATA_W*NUM_INPUTS-1:0] act_in,
   output logic                         busy,
   output logic                         done,
   layer_mac_scheduler_if.master        bus
);
   localparam int ACT_W = DATA_W * NUM_INPUTS;
   localparam int KW    = $clog2(NUM_INPUTS + 2);
   localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

   state_e            state_q, state_d;
   logic [KW-1:0]     k_q, k_d;
   logic [IDX_W-1:0]  n_q, n_d;
   logic [ACT_W-1:0]  act_q, act_d, act_rot;
   logic              mac_clr, mac_en;
   logic [DATA_W-1:0] mac_a, mac_b, acc;

   // Activations rotate one slot per product so act[k-1] is always in the low word;
   // after NUM_INPUTS rotations the register is back in its original order.
   if (NUM_INPUTS > 1) begin : g_rot
      assign act_rot = {act_q[DATA_W-1:0], act_q[ACT_W-1:DATA_W]};
   end else begin : g_norot
      assign act_rot = act_q;
   end

   always_comb begin
      state_d       = state_q;
      k_d           = k_q;
      n_d           = n_q;
      act_d         = act_q;
      mac_clr       = 1'b0;
      mac_en        = 1'b0;
      mac_a         = act_q[DATA_W-1:0];
      mac_b         = bus.rom_data;
      bus.rom_en    = 1'b0;
      bus.rom_addr  = '0;
      bus.out_valid = 1'b0;
      bus.out_data  = '0;
      bus.out_idx   = '0;
      busy          = (state_q != IDLE);
      done          = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = MAC;
               k_d     = '0;
               n_d     = '0;
               act_d   = act_in;
               mac_clr = 1'b1;
            end
         end
         MAC: begin
            if (k_q <= KW'(NUM_INPUTS)) begin
               bus.rom_en   = 1'b1;
               bus.rom_addr = ADDR_W'(rom_base(int'(n_q), NUM_INPUTS) + int'(k_q));
            end
            if (k_q != '0) mac_en = 1'b1;
            if (k_q != '0 && k_q <= KW'(NUM_INPUTS)) act_d = act_rot;
            if (k_q == KW'(NUM_INPUTS + 1)) begin
               // bias step: rom_data*1 reuses the multiplier path unchanged
               mac_a   = bus.rom_data;
               mac_b   = DATA_W'(1);
               k_d     = '0;
               state_d = EMIT;
            end else begin
               k_d = k_q + KW'(1);
            end
         end
         EMIT: begin
            bus.out_valid = 1'b1;
            bus.out_data  = relu16(acc);
            bus.out_idx   = n_q;
            if (bus.out_ready) begin
               if (n_q == IDX_W'(NUM_NEURONS - 1)) begin
                  state_d = DONE;
               end else begin
                  n_d     = n_q + IDX_W'(1);
                  mac_clr = 1'b1;
                  state_d = MAC;
               end
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         k_q     <= '0;
         n_q     <= '0;
         act_q   <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         n_q     <= n_d;
         act_q   <= act_d;
      end
   end

   mac16 u_mac (
      .clk   (clk),
      .reset (reset),
      .clr   (mac_clr),
      .en    (mac_en),
      .a     (mac_a),
      .b     (mac_b),
      .acc   (acc)
   );
endmodule

// File: tb/tb_layer_mac_scheduler.sv
// Directed bench for layer_mac_scheduler: 10 inputs, 2 neurons, ROM modelled with 1-cycle latency.
module tb_layer_mac_scheduler;
   localparam int NI = 10;

   typedef struct {
      shortint     act [NI];
      logic [15:0] exp0;
      logic [15:0] exp1;
   } vec_t;

   logic            clk = 1'b0;
   logic            reset;
   logic            start;
   logic [16*NI-1:0] act_in;
   logic            busy;
   logic            done;

   layer_mac_scheduler_if #(.ADDR_W(8), .IDX_W(1)) bus ();

   layer_mac_scheduler #(.NUM_INPUTS(NI), .NUM_NEURONS(2), .ADDR_W(8)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .act_in (act_in),
      .busy   (busy),
      .done   (done),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   logic [15:0] rom [0:255];
   always @(posedge clk) begin
      if (bus.rom_en) bus.rom_data <= rom[bus.rom_addr];
      else            bus.rom_data <= 16'h0000;
   end

   int          checks = 0;
   int          errors = 0;
   logic [15:0] got_data [$];
   int          got_idx [$];
   int          done_cnt = 0;

   always @(negedge clk) begin
      if (!reset) begin
         if (bus.out_valid && bus.out_ready) begin
            got_data.push_back(bus.out_data);
            got_idx.push_back(int'(bus.out_idx));
         end
         if (done) done_cnt++;
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, got, exp);
      end
   endtask

   function automatic logic [16*NI-1:0] pack(input shortint a [NI]);
      logic [16*NI-1:0] r;
      for (int i = 0; i < NI; i++) r[16*i +: 16] = a[i];
      return r;
   endfunction

   task automatic clear_log();
      got_data.delete();
      got_idx.delete();
      done_cnt = 0;
   endtask

   task automatic start_layer(input shortint a [NI]);
      @(posedge clk); #1;
      start  = 1'b1;
      act_in = pack(a);
      @(posedge clk); #1;
      start  = 1'b0;
      act_in = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
   endtask

   task automatic wait_valid(output int lat);
      lat = 1;
      while (!bus.out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (!done && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, "_done_seen"}, 32'(done), 32'd1);
      check({tag, "_busy_at_done"}, 32'(busy), 32'd1);
      @(posedge clk); #1;
      check({tag, "_busy_after"}, 32'(busy), 32'd0);
      check({tag, "_done_after"}, 32'(done), 32'd0);
   endtask

   task automatic check_results(input string tag, input logic [15:0] e0, input logic [15:0] e1);
      check({tag, "_count"}, got_data.size(), 32'd2);
      check({tag, "_done_cnt"}, done_cnt, 32'd1);
      if (got_data.size() == 2) begin
         check({tag, "_d0"}, got_data[0], e0);
         check({tag, "_i0"}, got_idx[0], 32'd0);
         check({tag, "_d1"}, got_data[1], e1);
         check({tag, "_i1"}, got_idx[1], 32'd1);
      end
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int lat;
      clear_log();
      bus.out_ready = 1'b1;
      start_layer(v.act);
      wait_valid(lat);
      check({tag, "_latency"}, lat, 32'd13);
      wait_done(tag);
      check_results(tag, v.exp0, v.exp1);
   endtask

   vec_t    vecs [8];
   shortint w0 [NI] = '{-60, -55, 7, 31, -4, 33, -34, -20, 44, -4};
   shortint sevens [NI] = '{7, 7, 7, 7, 7, 7, 7, 7, 7, 7};

   initial begin
      int lat;
      int n;
      for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
      for (int i = 0; i < NI; i++) begin
         rom[i]      = w0[i];
         rom[11 + i] = 16'd1000;
      end
      rom[10] = 16'd5;
      rom[21] = 16'd0;

      vecs[0] = '{'{1, 1, 1, 1, 1, 1, 1, 1, 1, 1},       16'd0,   16'd10000};
      vecs[1] = '{'{0, 0, 0, 0, 0, 0, 0, 0, 10, 0},      16'd445, 16'd10000};
      vecs[2] = '{'{4, 4, 4, 4, 4, 4, 4, 4, 4, 4},       16'd0,   16'd0};
      vecs[3] = '{'{0, 0, 0, 0, 0, 0, 0, 0, 0, 0},       16'd5,   16'd0};
      vecs[4] = '{'{-1, 0, 0, 0, 0, 0, 0, 0, 0, 0},      16'd65,  16'd0};
      vecs[5] = '{'{0, 0, 0, 2, 0, 3, 0, 0, 0, 0},       16'd166, 16'd5000};
      vecs[6] = '{'{0, 1200, 0, 0, 0, 0, 0, 0, 0, 0},    16'd0,   16'd20352};
      vecs[7] = '{'{0, 0, 0, 0, -3, 0, 0, 0, 0, 0},      16'd17,  16'd0};

      reset = 1'b1;
      start = 1'b0;
      act_in = '0;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_rom_en", 32'(bus.rom_en), 32'd0);
      check("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
      check("rst_valid", 32'(bus.out_valid), 32'd0);
      check("rst_data", 32'(bus.out_data), 32'd0);
      check("rst_idx", 32'(bus.out_idx), 32'd0);
      reset = 1'b0;

      for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Backpressure: neuron 0 held for 5 cycles, everything stable and no ROM reads
      clear_log();
      bus.out_ready = 1'b0;
      start_layer(vecs[1].act);
      wait_valid(lat);
      check("hold_latency", lat, 32'd13);
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         check($sformatf("hold_valid_c%0d", c), 32'(bus.out_valid), 32'd1);
         check($sformatf("hold_data_c%0d", c), 32'(bus.out_data), 32'd445);
         check($sformatf("hold_idx_c%0d", c), 32'(bus.out_idx), 32'd0);
         check($sformatf("hold_rom_en_c%0d", c), 32'(bus.rom_en), 32'd0);
      end
      check("hold_no_hs", got_data.size(), 32'd0);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      check("hold_valid_drop", 32'(bus.out_valid), 32'd0);
      wait_done("hold");
      check_results("hold", 16'd445, 16'd10000);

      // start during MAC step 4 and during DONE are both ignored
      clear_log();
      start_layer(vecs[1].act);
      repeat (4) @(posedge clk);
      #1;
      start  = 1'b1;
      act_in = pack(sevens);
      @(posedge clk); #1;
      start  = 1'b0;
      n = 0;
      while (!done && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check("restart_done_seen", 32'(done), 32'd1);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("restart_busy_after_done", 32'(busy), 32'd0);
      repeat (20) @(posedge clk);
      #1;
      check("restart_still_idle", 32'(busy), 32'd0);
      check_results("restart", 16'd445, 16'd10000);

      // Reset in the middle of neuron 1 accumulation
      clear_log();
      bus.out_ready = 1'b1;
      start_layer(vecs[1].act);
      n = 0;
      while (got_data.size() < 1 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("abort_first_out", got_data.size(), 32'd1);
      repeat (3) @(posedge clk);
      #1;
      check("abort_in_mac", 32'(bus.rom_en), 32'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_rom_en", 32'(bus.rom_en), 32'd0);
      check("abort_rom_addr", 32'(bus.rom_addr), 32'd0);
      check("abort_valid", 32'(bus.out_valid), 32'd0);
      check("abort_data", 32'(bus.out_data), 32'd0);
      check("abort_idx", 32'(bus.out_idx), 32'd0);
      reset = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      check("abort_no_partial", got_data.size(), 32'd1);
      check("abort_no_done", done_cnt, 32'd0);
      run_vec(vecs[1], "after_abort");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
